peripheral_axi4_initiator: RTL

PERIPHERAL_AXI4_INITIATOR -- requirements
Module: peripheral_axi4_initiator

---
 rtl/peripheral_axi4_pkg.sv | 34 +++
 rtl/peripheral_axi4_watchdog.sv | 26 ++
 rtl/peripheral_axi4_initiator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_axi4_pkg.sv
// Shared AXI4 initiator definitions: FSM states, burst/response encodings, helpers.
package peripheral_axi4_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RADDR = 3'd4,
    RDATA = 3'd5,
    DONE  = 3'd6
  } axi_state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESPONSE_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESPONSE_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESPONSE_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESPONSE_DECERR = 2'b11;

  localparam int WDOG_W = 16;

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == AXI_RESPONSE_SLVERR) || (r == AXI_RESPONSE_DECERR);
  endfunction

  // Severity grows with the encoding: OKAY < EXOKAY < SLVERR < DECERR.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/peripheral_axi4_watchdog.sv
// Stall watchdog: counts busy cycles without a handshake, flags expiry at saturation.
module peripheral_axi4_watchdog
  import peripheral_axi4_pkg::*;
(
  input  logic aclk,
  input  logic aresetn,
  input  logic busy,
  input  logic handshake,
  output logic expired
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (!busy || handshake) begin
      cnt <= '0;
    end else if (cnt != {WDOG_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = busy && (cnt == {WDOG_W{1'b1}});

endmodule

// File: rtl/peripheral_axi4_initiator.sv
// Single-outstanding AXI4 burst initiator. Optional stall watchdog is enabled
// by defining PERIPHERAL_AXI4_INITIATOR_TIMEOUT_EN.
module peripheral_axi4_initiator
  import peripheral_axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rsp_valid,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_err,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awadr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_WIDTH-1:0]     wid,
  output logic [DATA_WIDTH-1:0]   wrdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic                    arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  axi_state_e              state, state_nxt;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              len_q;
  logic [2:0]              size_q;
  logic [3:0]              beat_q;
  logic [1:0]              resp_q;
  logic                    err_q;
  logic                    timeout;
  logic                    w_hs;
  logic                    last_beat;
  logic                    r_end;

  assign last_beat = (beat_q == len_q);
  assign w_hs      = (state == WDATA) && wd_valid && wready;
  assign r_end     = rlast || last_beat;

`ifdef PERIPHERAL_AXI4_INITIATOR_TIMEOUT_EN
  logic busy;
  logic any_hs;
  assign busy   = (state != IDLE) && (state != DONE);
  assign any_hs = (awvalid && awready) || (arvalid && arready) || (wvalid && wready) ||
                  (bvalid && bready) || (rvalid && rready);
  peripheral_axi4_watchdog u_wdog (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .busy      (busy),
    .handshake (any_hs),
    .expired   (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_write ? WADDR : RADDR;
      WADDR:   if (awready) state_nxt = WDATA;
      WDATA:   if (w_hs && last_beat) state_nxt = WRESP;
      WRESP:   if (bvalid) state_nxt = DONE;
      RADDR:   if (arready) state_nxt = RDATA;
      RDATA:   if (rvalid && r_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = DONE;
  end

  always_comb begin
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    arvalid   = 1'b0;
    wvalid    = 1'b0;
    wd_ready  = 1'b0;
    wlast     = 1'b0;
    wrdata    = '0;
    wstrb     = '0;
    bready    = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:  cmd_ready = 1'b1;
      WADDR: awvalid   = 1'b1;
      WDATA: begin
        wvalid   = wd_valid;
        wd_ready = wready;
        wlast    = last_beat;
        wrdata   = wd_data;
        wstrb    = wd_strb;
      end
      WRESP: bready    = 1'b1;
      RADDR: arvalid   = 1'b1;
      RDATA: rready    = 1'b1;
      DONE:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command capture, beat counting and completion-status accumulation
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      beat_q <= '0;
      resp_q <= AXI_RESPONSE_OKAY;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          id_q   <= cmd_id;
          addr_q <= cmd_addr;
          len_q  <= cmd_len;
          size_q <= cmd_size;
          beat_q <= '0;
          resp_q <= AXI_RESPONSE_OKAY;
          err_q  <= 1'b0;
        end
        WDATA: if (w_hs) beat_q <= beat_q + 1'b1;
        WRESP: if (bvalid) begin
          resp_q <= bresp;
          err_q  <= resp_is_err(bresp) || (bid != id_q);
        end
        RDATA: if (rvalid) begin
          beat_q <= beat_q + 1'b1;
          resp_q <= resp_worst(resp_q, rresp);
          err_q  <= err_q || resp_is_err(rresp) || (rid != id_q) || (rlast && !last_beat);
        end
        default: ;
      endcase
      if (timeout) begin
        resp_q <= AXI_RESPONSE_DECERR;
        err_q  <= 1'b1;
      end
    end
  end

  // Read-data forwarding stage: one registered cycle behind the R channel
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= (state == RDATA) && rvalid;
      rd_last  <= (state == RDATA) && rvalid && r_end;
      if ((state == RDATA) && rvalid) rd_data <= rdata;
    end
  end

  assign awid     = id_q;
  assign awadr    = addr_q;
  assign awlen    = len_q;
  assign awsize   = size_q;
  assign awburst  = AXI_BURST_INCR;
  assign awlock   = 1'b0;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign wid      = id_q;
  assign arid     = id_q;
  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arsize   = size_q;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign rsp_id   = id_q;
  assign rsp_resp = resp_q;
  assign rsp_err  = err_q;

endmodule
